// File: rtl/convergence_feeder.sv
// Feeds one pass of new centroids to the convergence check block, waits for its
// verdict, then commits the buffer as the previous-pass centroids.
module convergence_feeder #(
  parameter int dataWidth      = 91,
  parameter int centroid_num   = 8,
  parameter int timeout_cycles = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [dataWidth-1:0] thresh_in,
  input  logic                 new_cent_wr,
  input  logic [2:0]           new_cent_idx,
  input  logic [dataWidth-1:0] new_cent_data,
  input  logic                 has_converged,
  input  logic                 converge_res_available,
  output logic                 convergence_reg_en,
  output logic                 convergence_regs_reset,
  output logic [dataWidth-1:0] new_centroid_in,
  output logic [2:0]           cent_num,
  output logic [dataWidth-1:0] thresh_hold,
  output logic [dataWidth-1:0] old_centroid_reg_1,
  output logic [dataWidth-1:0] old_centroid_reg_2,
  output logic [dataWidth-1:0] old_centroid_reg_3,
  output logic [dataWidth-1:0] old_centroid_reg_4,
  output logic [dataWidth-1:0] old_centroid_reg_5,
  output logic [dataWidth-1:0] old_centroid_reg_6,
  output logic [dataWidth-1:0] old_centroid_reg_7,
  output logic [dataWidth-1:0] old_centroid_reg_8,
  output logic                 busy,
  output logic                 done,
  output logic                 converged,
  output logic                 error
);

  localparam int WCW = $clog2(timeout_cycles + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STREAM, S_WAIT, S_UPDATE, S_CLEAR, S_DONE
  } state_t;

  state_t state, state_nx;
  logic [2:0]     cnt;
  logic [WCW-1:0] wait_cnt;
  logic           timeout;
  logic [centroid_num-1:0][dataWidth-1:0] buf_q;
  logic [centroid_num-1:0][dataWidth-1:0] old_q;

  assign timeout = (state == S_WAIT) && !converge_res_available &&
                   (wait_cnt == WCW'(timeout_cycles - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_STREAM;
      S_STREAM: if (cnt == 3'(centroid_num - 1)) state_nx = S_WAIT;
      S_WAIT: begin
        if (converge_res_available) state_nx = S_UPDATE;
        else if (timeout)           state_nx = S_CLEAR;
      end
      S_UPDATE: state_nx = S_CLEAR;
      S_CLEAR:  state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // All outputs decode from state/counter/registers; no input reaches them directly.
  assign busy                   = (state != S_IDLE);
  assign done                   = (state == S_DONE);
  assign convergence_reg_en     = (state == S_STREAM);
  assign convergence_regs_reset = (state != S_CLEAR);
  assign cent_num               = (state == S_STREAM) ? cnt : 3'd0;
  assign new_centroid_in        = (state == S_STREAM) ? buf_q[cnt] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      wait_cnt    <= '0;
      thresh_hold <= '0;
      converged   <= 1'b0;
      error       <= 1'b0;
    end else begin
      cnt      <= (state == S_STREAM) ? cnt + 3'd1 : 3'd0;
      wait_cnt <= (state == S_WAIT) ? wait_cnt + WCW'(1) : '0;
      if (state == S_IDLE && start) thresh_hold <= thresh_in;
      if (state == S_WAIT && converge_res_available) converged <= has_converged;
      else if (timeout)                              converged <= 1'b0;
      // A start accepted from IDLE clears the sticky flag; writes in that cycle are legal.
      if (state == S_IDLE && start)                         error <= 1'b0;
      else if ((new_cent_wr && state != S_IDLE) || timeout) error <= 1'b1;
    end
  end

  genvar k;
  generate
    for (k = 0; k < centroid_num; k++) begin : g_ent
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          buf_q[k] <= '0;
          old_q[k] <= '0;
        end else begin
          if (state == S_IDLE && new_cent_wr && new_cent_idx == 3'(k))
            buf_q[k] <= new_cent_data;
          if (state == S_UPDATE) old_q[k] <= buf_q[k];
        end
      end
    end
  endgenerate

  assign old_centroid_reg_1 = old_q[0];
  assign old_centroid_reg_2 = old_q[1];
  assign old_centroid_reg_3 = old_q[2];
  assign old_centroid_reg_4 = old_q[3];
  assign old_centroid_reg_5 = old_q[4];
  assign old_centroid_reg_6 = old_q[5];
  assign old_centroid_reg_7 = old_q[6];
  assign old_centroid_reg_8 = old_q[7];

endmodule

// File: tb/tb_convergence_feeder.sv
// Directed bench for convergence_feeder: normal pass, illegal access, stream-time
// result, write-first start, WAIT timeout and mid-pass reset.
module tb_convergence_feeder;
  localparam int DW = 91;

  logic          clk = 1'b0;
  logic          rst, start, new_cent_wr, has_converged, converge_res_available;
  logic [DW-1:0] thresh_in, new_cent_data;
  logic [2:0]    new_cent_idx;
  logic          en, regs_reset, busy, done, converged, error;
  logic [DW-1:0] new_centroid_in, thresh_hold;
  logic [2:0]    cent_num;
  logic [DW-1:0] o1, o2, o3, o4, o5, o6, o7, o8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  convergence_feeder dut (
    .clk(clk), .rst(rst), .start(start), .thresh_in(thresh_in),
    .new_cent_wr(new_cent_wr), .new_cent_idx(new_cent_idx), .new_cent_data(new_cent_data),
    .has_converged(has_converged), .converge_res_available(converge_res_available),
    .convergence_reg_en(en), .convergence_regs_reset(regs_reset),
    .new_centroid_in(new_centroid_in), .cent_num(cent_num), .thresh_hold(thresh_hold),
    .old_centroid_reg_1(o1), .old_centroid_reg_2(o2), .old_centroid_reg_3(o3),
    .old_centroid_reg_4(o4), .old_centroid_reg_5(o5), .old_centroid_reg_6(o6),
    .old_centroid_reg_7(o7), .old_centroid_reg_8(o8),
    .busy(busy), .done(done), .converged(converged), .error(error)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_rreset"}, regs_reset, 1);
    chk({tag, "_cnum"}, cent_num, 0);
    chk({tag, "_data"}, new_centroid_in, 0);
    chk({tag, "_thresh"}, thresh_hold, 0);
    chk({tag, "_old1"}, o1, 0);
    chk({tag, "_old8"}, o8, 0);
    chk({tag, "_conv"}, converged, 0);
    chk({tag, "_err"}, error, 0);
  endtask

  initial begin
    rst = 1; start = 0; thresh_in = '0; new_cent_wr = 0; new_cent_idx = '0;
    new_cent_data = '0; has_converged = 0; converge_res_available = 0;
    #2;
    chk_reset_vals("rst");
    step(); step();
    rst = 0;

    // load buffer[i] = i
    for (int i = 0; i < 8; i++) begin
      new_cent_wr = 1; new_cent_idx = 3'(i); new_cent_data = DW'(i);
      step();
    end
    new_cent_wr = 0;
    chk("idle_en", en, 0);
    chk("idle_busy", busy, 0);
    chk("idle_err", error, 0);

    // pass 1: normal, converged answer three cycles into WAIT
    thresh_in = 10; start = 1; step(); start = 0;
    for (int c = 0; c < 8; c++) begin
      chk("p1_cnum", cent_num, c);
      chk("p1_data", new_centroid_in, c);
      chk("p1_en", en, 1);
      step();
    end
    chk("p1_wait_en", en, 0);
    chk("p1_thresh", thresh_hold, 10);
    chk("p1_wait_busy", busy, 1);
    step(); step();
    converge_res_available = 1; has_converged = 1; step();
    converge_res_available = 0; has_converged = 0;
    chk("p1_upd_conv", converged, 1);
    chk("p1_upd_rreset", regs_reset, 1);
    chk("p1_upd_done", done, 0);
    step();
    chk("p1_clr_rreset", regs_reset, 0);
    chk("p1_old8", o8, 7);
    chk("p1_old1", o1, 0);
    chk("p1_old4", o4, 3);
    step();
    chk("p1_done", done, 1);
    chk("p1_done_rreset", regs_reset, 1);
    step();
    chk("p1_done_end", done, 0);
    chk("p1_idle_busy", busy, 0);
    chk("p1_idle_conv", converged, 1);
    chk("p1_idle_err", error, 0);

    // pass 2: start and write mid-stream are ignored, write flags error
    start = 1; step(); start = 0;
    step(); step();
    start = 1; new_cent_wr = 1; new_cent_idx = 7; new_cent_data = 11; step();
    start = 0; new_cent_wr = 0;
    chk("p2_err", error, 1);
    chk("p2_cnum_cont", cent_num, 3);
    repeat (5) step();
    chk("p2_wait_en", en, 0);
    converge_res_available = 1; has_converged = 0; step();
    converge_res_available = 0;
    chk("p2_conv", converged, 0);
    step(); step();
    chk("p2_done", done, 1);
    step();
    chk("p2_idle_busy", busy, 0);
    chk("p2_err_sticky", error, 1);

    // pass 3: result during STREAM ignored; buffer[7] kept
    start = 1; step(); start = 0;
    chk("p3_err_clr", error, 0);
    converge_res_available = 1; has_converged = 1; step();
    converge_res_available = 0; has_converged = 0;
    chk("p3_stream_cnum", cent_num, 1);
    chk("p3_stream_conv", converged, 0);
    chk("p3_stream_en", en, 1);
    repeat (6) step();
    chk("p3_cnum7", cent_num, 7);
    chk("p3_buf7_kept", new_centroid_in, 7);
    step();
    converge_res_available = 1; has_converged = 1; step();
    converge_res_available = 0; has_converged = 0;
    step(); step(); step();
    chk("p3_idle_busy", busy, 0);
    chk("p3_conv", converged, 1);

    // pass 4: same-cycle write + start (write-first), then WAIT timeout
    new_cent_wr = 1; new_cent_idx = 0; new_cent_data = 5; start = 1; step();
    new_cent_wr = 0; start = 0;
    chk("p4_wfirst_data", new_centroid_in, 5);
    chk("p4_wfirst_cnum", cent_num, 0);
    chk("p4_wfirst_err", error, 0);
    repeat (8) step();
    repeat (15) step();
    chk("p4_wait16_busy", busy, 1);
    chk("p4_wait16_err", error, 0);
    chk("p4_wait16_rreset", regs_reset, 1);
    chk("p4_wait16_conv", converged, 1);
    step();
    chk("p4_to_err", error, 1);
    chk("p4_to_conv", converged, 0);
    chk("p4_to_rreset", regs_reset, 0);
    chk("p4_to_old1", o1, 0);
    step();
    chk("p4_done", done, 1);
    step();
    chk("p4_done_end", done, 0);
    chk("p4_idle_busy", busy, 0);
    chk("p4_err_sticky", error, 1);
    chk("p4_old1_kept", o1, 0);
    chk("p4_old8_kept", o8, 7);

    // pass 5: reset in stream cycle 5, then a normal pass
    thresh_in = 33; start = 1; step(); start = 0;
    repeat (4) step();
    chk("p5_cnum", cent_num, 4);
    chk("p5_thresh", thresh_hold, 33);
    rst = 1; #1;
    chk_reset_vals("p5_rst");
    step();
    chk("p5_rst_done_a", done, 0);
    step();
    chk("p5_rst_done_b", done, 0);
    rst = 0;
    new_cent_wr = 1; new_cent_idx = 7; new_cent_data = 42; step();
    new_cent_wr = 0;
    thresh_in = 3; start = 1; step(); start = 0;
    chk("p5_buf0_cleared", new_centroid_in, 0);
    chk("p5_thresh2", thresh_hold, 3);
    chk("p5_en", en, 1);
    repeat (8) step();
    converge_res_available = 1; has_converged = 1; step();
    converge_res_available = 0; has_converged = 0;
    step();
    chk("p5_old8", o8, 42);
    chk("p5_old1", o1, 0);
    step();
    chk("p5_done", done, 1);
    step();
    chk("p5_idle_busy", busy, 0);
    chk("p5_conv", converged, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/convergence_feeder.md
CONVERGENCE_FEEDER -- requirements
Module: convergence_feeder

Interface
REQ-001 Parameter dataWidth, default 91, packed centroid width (7 coordinates x 13 bits).
REQ-002 Parameter centroid_num, default 8, number of centroids per pass.
REQ-003 Parameter timeout_cycles, default 16, maximum WAIT cycles before error.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  controller pulse; begins one convergence pass.
REQ-008 thresh_in  in  dataWidth  threshold, latched on an accepted start.
REQ-009 new_cent_wr  in  1  write strobe into the new-centroid buffer.
REQ-010 new_cent_idx  in  3  buffer write index 0..7.
REQ-011 new_cent_data  in  dataWidth  new centroid value.
REQ-012 has_converged  in  1  result from the convergence check block.
REQ-013 converge_res_available  in  1  result-valid from the convergence check block.
REQ-014 convergence_reg_en  out  1  enables accumulation in the check block.
REQ-015 convergence_regs_reset  out  1  active-low clear of the check block's registers.
REQ-016 new_centroid_in  out  dataWidth  streamed new centroid.
REQ-017 cent_num  out  3  index of the streamed centroid.
REQ-018 thresh_hold  out  dataWidth  latched threshold.
REQ-019 old_centroid_reg_1..old_centroid_reg_8  out  dataWidth each  committed previous-pass centroids.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse at the end of a pass.
REQ-022 converged  out  1  has_converged latched from the last completed pass.
REQ-023 error  out  1  sticky flag for timeout or an illegal write.

Function
REQ-024 FSM states: IDLE, STREAM, WAIT, UPDATE, CLEAR, DONE, registered, one-hot or binary.
REQ-025 IDLE: new_cent_wr writes buffer[new_cent_idx] on the next clock edge; start=1 latches thresh_in and moves to STREAM with the counter set to 0.
REQ-026 STREAM: lasts exactly 8 cycles; convergence_reg_en=1; cent_num=counter; new_centroid_in=buffer[counter]; counter increments each cycle; at counter=7 the FSM moves to WAIT.
REQ-027 Latency: start sampled at edge 0 gives cent_num=0 in cycle 1 and cent_num=7 in cycle 8; WAIT begins in cycle 9.
REQ-028 WAIT: convergence_reg_en=0; on converge_res_available=1, converged <= has_converged and the FSM moves to UPDATE.
REQ-029 WAIT timeout: after timeout_cycles cycles without converge_res_available, error <= 1, converged <= 0, and the FSM moves to CLEAR without entering UPDATE.
REQ-030 UPDATE: one cycle; old_centroid_reg_k <= buffer[k-1] for all k in the same edge.
REQ-031 CLEAR: one cycle with convergence_regs_reset=0; convergence_regs_reset=1 in every other state.
REQ-032 DONE: done=1 for one cycle, then the FSM returns to IDLE.
REQ-033 start while busy=1 is ignored and does not set error.
REQ-034 new_cent_wr while busy=1 leaves the buffer unchanged and sets error.
REQ-035 start and new_cent_wr in the same IDLE cycle: the write completes and the pass starts; stream cycle 1 already sees the written value (write-first).
REQ-036 converge_res_available during STREAM is ignored.
REQ-037 Outputs are registered or decoded from state/counter only; there is no combinational path from has_converged to any output.
REQ-038 error clears only on rst, or on a start accepted from IDLE.

Reset
REQ-039 rst=1 forces IDLE immediately, regardless of clk.
REQ-040 Reset values: counter=0, buffer=0, old_centroid_reg_1..8=0, thresh_hold=0, convergence_reg_en=0, convergence_regs_reset=1, cent_num=0, new_centroid_in=0, busy=0, done=0, converged=0, error=0.
REQ-041 Reset mid-pass abandons the pass: no UPDATE, no done pulse, all values as in REQ-040.

Verification
REQ-042 Load buffer[i]=i for i=0..7, start with thresh_in=10 -> cent_num 0..7 on cycles 1..8, new_centroid_in=i, en=1 for exactly 8 cycles, thresh_hold=10.
REQ-043 Respond converge_res_available=1 with has_converged=1 three cycles into WAIT -> converged=1, old_centroid_reg_8=7, one-cycle regs_reset=0, then done pulse, busy=0.
REQ-044 No converge_res_available -> error=1 after 16 WAIT cycles, old regs unchanged, done pulses, converged=0.
REQ-045 start and new_cent_wr (idx 7, data 11) mid-STREAM -> both ignored, error=1, buffer[7] still 7 on the next pass.
REQ-046 Assert rst in cycle 5 of STREAM -> all outputs at reset values, old regs 0, no done pulse; a new start afterwards runs a normal pass.
REQ-047 Same-cycle write idx 0 = 5 and start -> first streamed new_centroid_in=5.
